// File: rtl/decode_issue_unit_if.sv
// Decode/issue bundle: decode-side inputs, writeback port,
// and the registered Execute-stage outputs.
//   slave  : the decode_issue_unit side
//   master : whoever drives decode and consumes Execute
interface decode_issue_unit_if #(
    parameter int XLEN = 32
);
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            ValidD;
    logic            FlushE;
    logic            RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;

    logic            StallD;
    logic            ValidE;
    logic            IllegalE;
    logic [4:0]      Rs1E;
    logic [4:0]      Rs2E;
    logic [4:0]      RdE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] ExtImmE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            JumpE;
    logic            BranchE;
    logic            AluSrcE;
    logic            JalrE;
    logic [1:0]      ResultSrcE;
    logic [1:0]      StoreTypeE;
    logic [2:0]      LoadTypeE;
    logic [2:0]      BranchTypeE;
    logic [3:0]      ALUControlE;

    modport slave (
        input  InstrD, PCD, PCPlus4D, ValidD, FlushE,
        input  RegWriteW, RdW, ResultW,
        output StallD, ValidE, IllegalE,
        output Rs1E, Rs2E, RdE, RD1E, RD2E, ExtImmE,
        output PCE, PCPlus4E,
        output RegWriteE, MemWriteE, JumpE, BranchE,
        output AluSrcE, JalrE, ResultSrcE, StoreTypeE,
        output LoadTypeE, BranchTypeE, ALUControlE
    );

    modport master (
        output InstrD, PCD, PCPlus4D, ValidD, FlushE,
        output RegWriteW, RdW, ResultW,
        input  StallD, ValidE, IllegalE,
        input  Rs1E, Rs2E, RdE, RD1E, RD2E, ExtImmE,
        input  PCE, PCPlus4E,
        input  RegWriteE, MemWriteE, JumpE, BranchE,
        input  AluSrcE, JalrE, ResultSrcE, StoreTypeE,
        input  LoadTypeE, BranchTypeE, ALUControlE
    );
endinterface

// File: rtl/decode_issue_unit.sv
// Decode stage + register file + ID/EX pipeline register.
// Ports: clk, rst (sync, active-high), bus (slave modport).
module decode_issue_unit #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input logic                clk,
    input logic                rst,
    decode_issue_unit_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ResultSrc: 00 ALU, 01 memory, 10 PC+4, 11 PC+imm
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_PCI = 2'b11;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
    } imm_t;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       jump;
        logic       branch;
        logic       alusrc;
        logic       jalr;
        logic [1:0] resultsrc;
        logic [1:0] storetype;
        logic [2:0] loadtype;
        logic [2:0] branchtype;
        logic [3:0] aluctl;
    } ctrl_t;

    logic [31:0] i;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    assign i   = bus.InstrD;
    assign op  = i[6:0];
    assign f3  = i[14:12];
    assign rd  = i[11:7];
    assign rs1 = i[19:15];
    assign rs2 = i[24:20];

    ctrl_t      ctrl, ctrl_d;
    imm_t       immsrc;
    logic       use1, use2, used;
    logic [3:0] alu_f;

    always_comb begin
        alu_f = ALU_ADD;
        unique case (f3)
            3'b000: alu_f = (op == OP_REG && i[30]) ? ALU_SUB : ALU_ADD;
            3'b001: alu_f = ALU_SLL;
            3'b010: alu_f = ALU_SLT;
            3'b011: alu_f = ALU_SLTU;
            3'b100: alu_f = ALU_XOR;
            3'b101: alu_f = i[30] ? ALU_SRA : ALU_SRL;
            3'b110: alu_f = ALU_OR;
            3'b111: alu_f = ALU_AND;
            default: alu_f = ALU_ADD;
        endcase
    end

    always_comb begin
        ctrl   = '0;
        immsrc = IMM_I;
        use1   = 1'b0;
        use2   = 1'b0;
        used   = 1'b0;
        unique case (1'b1)
            op == OP_LOAD: begin
                ctrl.regwrite  = 1'b1;
                ctrl.alusrc    = 1'b1;
                ctrl.resultsrc = RES_MEM;
                ctrl.loadtype  = f3;
                {use1, used}   = 2'b11;
            end
            op == OP_STORE: begin
                ctrl.memwrite  = 1'b1;
                ctrl.alusrc    = 1'b1;
                ctrl.storetype = f3[1:0];
                immsrc         = IMM_S;
                {use1, use2}   = 2'b11;
            end
            op == OP_REG: begin
                ctrl.regwrite      = 1'b1;
                ctrl.aluctl        = alu_f;
                {use1, use2, used} = 3'b111;
            end
            op == OP_IMM: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluctl   = alu_f;
                {use1, used}  = 2'b11;
            end
            op == OP_BRANCH: begin
                ctrl.branch     = 1'b1;
                ctrl.branchtype = f3;
                ctrl.aluctl     = ALU_SUB;
                immsrc          = IMM_B;
                {use1, use2}    = 2'b11;
            end
            op == OP_JAL: begin
                ctrl.regwrite  = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.resultsrc = RES_PC4;
                immsrc         = IMM_J;
                used           = 1'b1;
            end
            op == OP_JALR: begin
                ctrl.regwrite  = 1'b1;
                ctrl.jalr      = 1'b1;
                ctrl.alusrc    = 1'b1;
                ctrl.resultsrc = RES_PC4;
                {use1, used}   = 2'b11;
            end
            op == OP_LUI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluctl   = ALU_PASS;
                immsrc        = IMM_U;
                used          = 1'b1;
            end
            op == OP_AUIPC: begin
                ctrl.regwrite  = 1'b1;
                ctrl.resultsrc = RES_PCI;
                immsrc         = IMM_U;
                used           = 1'b1;
            end
            default: ;
        endcase
    end

    logic [31:0] imm32;
    always_comb begin
        unique case (immsrc)
            IMM_I: imm32 = {{20{i[31]}}, i[31:20]};
            IMM_S: imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B: imm32 = {{19{i[31]}}, i[31], i[7],
                            i[30:25], i[11:8], 1'b0};
            IMM_J: imm32 = {{11{i[31]}}, i[31], i[19:12],
                            i[20], i[30:21], 1'b0};
            IMM_U: imm32 = {i[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    // Indices >= 16 are only meaningful to flag on RV32E.
    logic illegal;
    assign illegal = (NREGS == 16) && bus.ValidD &&
                     ((use1 && rs1[4]) || (use2 && rs2[4]) ||
                      (used && rd[4]));

    always_comb begin
        ctrl_d = bus.ValidD ? ctrl : '0;
        if (illegal) begin
            ctrl_d.regwrite = 1'b0;
            ctrl_d.memwrite = 1'b0;
        end
    end

    logic [XLEN-1:0] rf [1:NREGS-1];
    logic            wr_en;
    assign wr_en = bus.RegWriteW && bus.RdW != 5'd0 &&
                   {27'b0, bus.RdW} < 32'(NREGS);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < NREGS; k++) rf[k] <= '0;
        end else if (wr_en) begin
            for (int k = 1; k < NREGS; k++)
                if (bus.RdW == 5'(k)) rf[k] <= bus.ResultW;
        end
    end

    logic [XLEN-1:0] rd1, rd2;
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int k = 1; k < NREGS; k++) begin
            if (rs1 == 5'(k)) rd1 = rf[k];
            if (rs2 == 5'(k)) rd2 = rf[k];
        end
        if (BYPASS != 0 && wr_en && bus.RdW == rs1) rd1 = bus.ResultW;
        if (BYPASS != 0 && wr_en && bus.RdW == rs2) rd2 = bus.ResultW;
    end

    // Load in Execute feeding the instruction in Decode.
    // Self-clears once the bubble drops ValidE.
    logic stall;
    assign stall = bus.ValidE && bus.ResultSrcE == RES_MEM &&
                   bus.RdE != 5'd0 && bus.ValidD &&
                   (bus.RdE == rs1 || bus.RdE == rs2);
    assign bus.StallD = stall;

    always_ff @(posedge clk) begin
        if (rst || bus.FlushE || stall) begin
            bus.ValidE      <= 1'b0;
            bus.IllegalE    <= 1'b0;
            bus.Rs1E        <= '0;
            bus.Rs2E        <= '0;
            bus.RdE         <= '0;
            bus.RD1E        <= '0;
            bus.RD2E        <= '0;
            bus.ExtImmE     <= '0;
            bus.PCE         <= '0;
            bus.PCPlus4E    <= '0;
            bus.RegWriteE   <= 1'b0;
            bus.MemWriteE   <= 1'b0;
            bus.JumpE       <= 1'b0;
            bus.BranchE     <= 1'b0;
            bus.AluSrcE     <= 1'b0;
            bus.JalrE       <= 1'b0;
            bus.ResultSrcE  <= '0;
            bus.StoreTypeE  <= '0;
            bus.LoadTypeE   <= '0;
            bus.BranchTypeE <= '0;
            bus.ALUControlE <= '0;
        end else begin
            bus.ValidE      <= bus.ValidD;
            bus.IllegalE    <= illegal;
            bus.Rs1E        <= rs1;
            bus.Rs2E        <= rs2;
            bus.RdE         <= rd;
            bus.RD1E        <= rd1;
            bus.RD2E        <= rd2;
            bus.ExtImmE     <= XLEN'($signed(imm32));
            bus.PCE         <= bus.PCD;
            bus.PCPlus4E    <= bus.PCPlus4D;
            bus.RegWriteE   <= ctrl_d.regwrite;
            bus.MemWriteE   <= ctrl_d.memwrite;
            bus.JumpE       <= ctrl_d.jump;
            bus.BranchE     <= ctrl_d.branch;
            bus.AluSrcE     <= ctrl_d.alusrc;
            bus.JalrE       <= ctrl_d.jalr;
            bus.ResultSrcE  <= ctrl_d.resultsrc;
            bus.StoreTypeE  <= ctrl_d.storetype;
            bus.LoadTypeE   <= ctrl_d.loadtype;
            bus.BranchTypeE <= ctrl_d.branchtype;
            bus.ALUControlE <= ctrl_d.aluctl;
        end
    end
endmodule

// File: tb/tb_decode_issue_unit.sv
// Directed bench for decode_issue_unit: three instances
// (default, BYPASS=0, NREGS=16) share one stimulus stream.
module tb_decode_issue_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_issue_unit_if #(.XLEN(32)) b0 ();
    decode_issue_unit_if #(.XLEN(32)) b1 ();
    decode_issue_unit_if #(.XLEN(32)) b2 ();

    decode_issue_unit #(.XLEN(32), .NREGS(32), .BYPASS(1))
        u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    decode_issue_unit #(.XLEN(32), .NREGS(32), .BYPASS(0))
        u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    decode_issue_unit #(.XLEN(32), .NREGS(16), .BYPASS(1))
        u2 (.clk(clk), .rst(rst), .bus(b2.slave));

    assign b1.InstrD    = b0.InstrD;
    assign b1.PCD       = b0.PCD;
    assign b1.PCPlus4D  = b0.PCPlus4D;
    assign b1.ValidD    = b0.ValidD;
    assign b1.FlushE    = b0.FlushE;
    assign b1.RegWriteW = b0.RegWriteW;
    assign b1.RdW       = b0.RdW;
    assign b1.ResultW   = b0.ResultW;
    assign b2.InstrD    = b0.InstrD;
    assign b2.PCD       = b0.PCD;
    assign b2.PCPlus4D  = b0.PCPlus4D;
    assign b2.ValidD    = b0.ValidD;
    assign b2.FlushE    = b0.FlushE;
    assign b2.RegWriteW = b0.RegWriteW;
    assign b2.RdW       = b0.RdW;
    assign b2.ResultW   = b0.ResultW;

    localparam logic [31:0] ADD_6_5_0  = 32'h0002_8333;
    localparam logic [31:0] ADD_9_0_0  = 32'h0000_04B3;
    localparam logic [31:0] LW_7_0_1   = 32'h0000_A383;
    localparam logic [31:0] ADD_8_7_2  = 32'h0023_8433;
    localparam logic [31:0] ADD_8_3_2  = 32'h0021_8433;
    localparam logic [31:0] ADDI_20_1  = 32'h0010_8A13;
    localparam logic [31:0] ADDI_1_M1  = 32'hFFF0_0093;
    localparam logic [31:0] BEQ_1_2_8  = 32'h0020_8463;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] ins, input logic v);
        b0.InstrD = ins;
        b0.ValidD = v;
    endtask

    task automatic wb(input logic we, input logic [4:0] r,
                      input logic [31:0] d);
        b0.RegWriteW = we;
        b0.RdW       = r;
        b0.ResultW   = d;
    endtask

    initial begin
        rst = 1'b1;
        b0.PCD = 32'h100;
        b0.PCPlus4D = 32'h104;
        b0.FlushE = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        put(BEQ_1_2_8, 1'b1);
        step();
        step();
        check("rst_valid", b0.ValidE, 1'b0);
        check("rst_branch", b0.BranchE, 1'b0);
        check("rst_rs2", b0.Rs2E, 5'd0);
        check("rst_pce", b0.PCE, 32'h0);
        check("rst_ill", b2.IllegalE, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_stall", b0.StallD, 1'b0);

        wb(1'b1, 5'd5, 32'hDEADBEEF);
        put(ADD_6_5_0, 1'b1);
        step();
        check("byp_on", b0.RD1E, 32'hDEADBEEF);
        check("byp_off", b1.RD1E, 32'h0);
        check("byp_rs1", b0.Rs1E, 5'd5);
        check("byp_rd", b0.RdE, 5'd6);
        check("byp_regw", b0.RegWriteE, 1'b1);
        check("byp_valid", b0.ValidE, 1'b1);
        wb(1'b0, 5'd0, 32'h0);
        step();
        check("rf_read", b1.RD1E, 32'hDEADBEEF);

        wb(1'b1, 5'd0, 32'h1234);
        put(ADD_9_0_0, 1'b1);
        step();
        check("x0_byp", b0.RD1E, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        step();
        check("x0_read", b0.RD1E, 32'h0);
        check("x0_read2", b0.RD2E, 32'h0);

        put(LW_7_0_1, 1'b1);
        #1;
        check("lw_nostall", b0.StallD, 1'b0);
        step();
        check("lw_res", b0.ResultSrcE, 2'b01);
        check("lw_ltype", b0.LoadTypeE, 3'd2);
        check("lw_rd", b0.RdE, 5'd7);
        put(ADD_8_7_2, 1'b1);
        #1;
        check("lu_stall", b0.StallD, 1'b1);
        step();
        check("lu_bubble", b0.ValidE, 1'b0);
        check("lu_bregw", b0.RegWriteE, 1'b0);
        check("lu_clear", b0.StallD, 1'b0);
        step();
        check("lu_issue", b0.ValidE, 1'b1);
        check("lu_rs1", b0.Rs1E, 5'd7);
        check("lu_rs2", b0.Rs2E, 5'd2);
        check("lu_after", b0.StallD, 1'b0);

        put(LW_7_0_1, 1'b1);
        step();
        put(ADD_8_3_2, 1'b1);
        #1;
        check("nd_stall", b0.StallD, 1'b0);
        step();
        check("nd_valid", b0.ValidE, 1'b1);
        check("nd_rs1", b0.Rs1E, 5'd3);

        put(BEQ_1_2_8, 1'b1);
        b0.FlushE = 1'b1;
        step();
        check("fl_valid", b0.ValidE, 1'b0);
        check("fl_branch", b0.BranchE, 1'b0);
        b0.FlushE = 1'b0;
        step();
        check("br_branch", b0.BranchE, 1'b1);
        check("br_imm", b0.ExtImmE, 32'h8);
        check("br_alu", b0.ALUControlE, 4'd1);
        check("br_regw", b0.RegWriteE, 1'b0);
        check("br_pc", b0.PCE, 32'h100);
        check("br_pc4", b0.PCPlus4E, 32'h104);

        put(LW_7_0_1, 1'b1);
        step();
        put(ADD_8_7_2, 1'b1);
        b0.FlushE = 1'b1;
        #1;
        check("fs_stall", b0.StallD, 1'b1);
        step();
        check("fs_bubble", b0.ValidE, 1'b0);
        b0.FlushE = 1'b0;
        #1;
        check("fs_clear", b0.StallD, 1'b0);
        step();
        check("fs_issue", b0.ValidE, 1'b1);
        check("fs_rd", b0.RdE, 5'd8);

        put(ADDI_1_M1, 1'b0);
        step();
        check("nv_valid", b0.ValidE, 1'b0);
        check("nv_regw", b0.RegWriteE, 1'b0);
        check("nv_src", b0.AluSrcE, 1'b0);
        check("nv_imm", b0.ExtImmE, 32'hFFFFFFFF);
        put(ADDI_1_M1, 1'b1);
        step();
        check("ai_regw", b0.RegWriteE, 1'b1);
        check("ai_src", b0.AluSrcE, 1'b1);
        check("ai_imm", b0.ExtImmE, 32'hFFFFFFFF);

        put(ADDI_20_1, 1'b1);
        step();
        check("e_ill", b2.IllegalE, 1'b1);
        check("e_regw", b2.RegWriteE, 1'b0);
        check("e_valid", b2.ValidE, 1'b1);
        check("i_ill", b0.IllegalE, 1'b0);
        check("i_regw", b0.RegWriteE, 1'b1);

        put(LW_7_0_1, 1'b1);
        step();
        put(ADD_8_7_2, 1'b1);
        wb(1'b1, 5'd5, 32'h55);
        #1;
        check("rs_stall", b0.StallD, 1'b1);
        rst = 1'b1;
        step();
        check("rs_valid", b0.ValidE, 1'b0);
        check("rs_res", b0.ResultSrcE, 2'b00);
        check("rs_rd", b0.RdE, 5'd0);
        rst = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        #1;
        check("rs_nostall", b0.StallD, 1'b0);
        put(ADD_6_5_0, 1'b1);
        step();
        check("rs_x5", b0.RD1E, 32'h0);
        check("rs_x5_nb", b1.RD1E, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
